// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed MEM-stage data memory with a req/ready
// handshake and a fixed access latency (LATENCY cycles from request to
// response). Byte/half/word accesses use little-endian lanes; loads are
// sign- or zero-extended.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned or reserved-size accesses are rejected with err_o
//   undefined -> addresses are force-aligned, reserved size acts as word
module data_memory_ctrl #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_BYTES);
    localparam int unsigned WORDS  = DEPTH_BYTES / 4;
    localparam int unsigned CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        mem [WORDS];

    logic               commit_s;
    logic [ADDR_W-1:0]  acc_addr_s;
    logic               acc_we_s;
    logic [1:0]         acc_size_s;
    logic               acc_uns_s;
    logic [31:0]        acc_wdata_s;
    logic               acc_err_s;
    logic [ADDR_W-1:0]  acc_idx_s;
    logic [ADDR_W-3:0]  word_idx_s;
    logic [1:0]         lane_s;
    logic [31:0]        rd_word_s;
    logic [31:0]        load_val_s;
    logic [3:0]         be_s;
    logic [31:0]        wlane_s;
    logic               mem_we_s;
    logic               unused_addr_s;

    // Address bits above the memory size are deliberately ignored (wrap).
    assign unused_addr_s = ^addr_i[31:ADDR_W];

`ifdef DMEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction
`else
    function automatic logic [ADDR_W-1:0] align_addr(input logic [1:0] size,
                                                     input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        case (size)
            SZ_B:    r = a;
            SZ_H:    r = {a[ADDR_W-1:1], 1'b0};
            default: r = {a[ADDR_W-1:2], 2'b00};
        endcase
        return r;
    endfunction
`endif

    // Select the requested lane of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_B:    r = {{24{sh[7]  & ~uns}}, sh[7:0]};
            SZ_H:    r = {{16{sh[15] & ~uns}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Access fields: with single-cycle latency the request commits directly from the inputs.
    always_comb begin
        if (LATENCY == 1) begin
            acc_addr_s  = addr_i[ADDR_W-1:0];
            acc_we_s    = we_i;
            acc_size_s  = size_i;
            acc_uns_s   = unsigned_i;
            acc_wdata_s = wdata_i;
        end else begin
            acc_addr_s  = addr_q;
            acc_we_s    = we_q;
            acc_size_s  = size_q;
            acc_uns_s   = uns_q;
            acc_wdata_s = wdata_q;
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_err_s = is_misaligned(acc_size_s, acc_addr_s[1:0]);
        acc_idx_s = acc_addr_s;
`else
        acc_err_s = 1'b0;
        acc_idx_s = align_addr(acc_size_s, acc_addr_s);
`endif
        word_idx_s = acc_idx_s[ADDR_W-1:2];
        lane_s     = acc_idx_s[1:0];
        rd_word_s  = mem[word_idx_s];
        load_val_s = load_extract(rd_word_s, lane_s, acc_size_s, acc_uns_s);
        case (acc_size_s)
            SZ_B: begin
                be_s    = 4'b0001 << lane_s;
                wlane_s = {4{acc_wdata_s[7:0]}};
            end
            SZ_H: begin
                be_s    = 4'b0011 << lane_s;
                wlane_s = {2{acc_wdata_s[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wlane_s = acc_wdata_s;
            end
        endcase
    end

    // Next-state, request capture and output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        wdata_d  = wdata_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (req_i) begin
                    addr_d  = addr_i[ADDR_W-1:0];
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    wdata_d = wdata_i;
                    if (LATENCY == 1) begin
                        state_d  = ST_RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_RESP);
        busy_d  = (state_d == ST_WAIT);
        err_d   = commit_s & acc_err_s;
        if (commit_s && !acc_we_s) begin
            rdata_d = acc_err_s ? 32'h0000_0000 : load_val_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    assign mem_we_s = commit_s & acc_we_s & ~acc_err_s & rst_i;

    // State, captured request and registered outputs; reset drops any pending access.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0000_0000;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-enabled store into the array; the array itself is never cleared.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem[word_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: instance A uses LATENCY=3,
// instance B uses LATENCY=1. Expected responses are queued at issue time
// and checked by a monitor whenever ready_o is seen.
module tb_data_memory_ctrl;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, a_uns, b_req, b_we, b_uns;
    logic [1:0]  a_size, b_size;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ready, a_busy, a_err, b_ready, b_busy, b_err;
    logic [31:0] a_rdata, b_rdata;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] hold [2];
    int          n_cmp;
    int          n_fail;

    data_memory_ctrl #(.DEPTH_BYTES(1024), .LATENCY(3)) u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .req_i(a_req), .we_i(a_we), .size_i(a_size),
        .unsigned_i(a_uns), .addr_i(a_addr), .wdata_i(a_wdata),
        .ready_o(a_ready), .busy_o(a_busy), .rdata_o(a_rdata), .err_o(a_err)
    );

    data_memory_ctrl #(.DEPTH_BYTES(1024), .LATENCY(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .req_i(b_req), .we_i(b_we), .size_i(b_size),
        .unsigned_i(b_uns), .addr_i(b_addr), .wdata_i(b_wdata),
        .ready_o(b_ready), .busy_o(b_busy), .rdata_o(b_rdata), .err_o(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready_o pops one expectation from its instance's queue.
    always @(negedge clk) begin
        exp_t e;
        if (a_ready) begin
            if (qa.size() == 0) begin
                check("a_spurious_ready", {31'b0, a_ready}, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_rdata", a_rdata, e.rd);
                check("a_err", {31'b0, a_err}, {31'b0, e.err});
            end
        end
        if (b_ready) begin
            if (qb.size() == 0) begin
                check("b_spurious_ready", {31'b0, b_ready}, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_rdata", b_rdata, e.rd);
                check("b_err", {31'b0, b_err}, {31'b0, e.err});
            end
        end
    end

    // One access: queue its expected response, drive it, check handshake timing.
    task automatic issue(input bit which, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit exp_err, input bit pulse);
        exp_t e;
        if (!we) hold[which] = exp_rd;
        e.rd  = hold[which];
        e.err = exp_err;
        if (which == 1'b0) qa.push_back(e);
        else               qb.push_back(e);
        @(posedge clk); #1;
        if (which == 1'b0) begin
            a_req = 1'b1; a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = 1'b1; b_we = we; b_size = size; b_uns = uns; b_addr = addr; b_wdata = wdata;
        end
        @(posedge clk); #1;
        if (which == 1'b0) begin
            a_req = pulse;
            @(negedge clk);
            check("a_busy_c1", {31'b0, a_busy}, 32'd1);
            check("a_ready_c1", {31'b0, a_ready}, 32'd0);
            @(posedge clk); #1;
            a_req = pulse;
            @(negedge clk);
            check("a_busy_c2", {31'b0, a_busy}, 32'd1);
            check("a_ready_c2", {31'b0, a_ready}, 32'd0);
            @(posedge clk); #1;
            a_req = 1'b0;
            @(negedge clk);
            check("a_busy_c3", {31'b0, a_busy}, 32'd0);
            check("a_ready_c3", {31'b0, a_ready}, 32'd1);
        end else begin
            b_req = 1'b0;
            @(negedge clk);
            check("b_busy_c1", {31'b0, b_busy}, 32'd0);
            check("b_ready_c1", {31'b0, b_ready}, 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        if (which == 1'b0) check("a_ready_after", {31'b0, a_ready}, 32'd0);
        else               check("b_ready_after", {31'b0, b_ready}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_a_ready"}, {31'b0, a_ready}, 32'd0);
        check({tag, "_a_busy"},  {31'b0, a_busy},  32'd0);
        check({tag, "_a_err"},   {31'b0, a_err},   32'd0);
        check({tag, "_a_rdata"}, a_rdata, 32'd0);
        check({tag, "_b_ready"}, {31'b0, b_ready}, 32'd0);
        check({tag, "_b_rdata"}, b_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        hold[0] = 32'd0; hold[1] = 32'd0;
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_size = 2'b00; a_uns = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
        b_req = 1'b0; b_we = 1'b0; b_size = 2'b00; b_uns = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Store word, load it back, then sub-word loads.
        issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        issue(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 0);
        issue(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0, 0);
        issue(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 0);
        issue(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0, 0);
        // Partial stores preserve untouched bytes.
        issue(0, 1, 2'b00, 0, 32'h11, 32'h00000055, 32'h0, 0, 0);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 0);
        issue(0, 1, 2'b01, 0, 32'h12, 32'h00001234, 32'h0, 0, 0);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h123455EF, 0, 0);
        // Misaligned word load and misaligned half store.
        issue(0, 0, 2'b10, 0, 32'h12, 32'h0, TRAP ? 32'h0 : 32'h123455EF, TRAP, 0);
        issue(0, 1, 2'b01, 0, 32'h13, 32'h0000AAAA, 32'h0, TRAP, 0);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, TRAP ? 32'h123455EF : 32'hAAAA55EF, 0, 0);
        // Address wrap, with requests pulsed while busy.
        issue(0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0, 0, 1);
        issue(0, 0, 2'b10, 0, 32'h000, 32'h0, 32'hCAFEF00D, 0, 1);

        // Reset during a store drops it.
        issue(0, 1, 2'b10, 0, 32'h20, 32'h00000000, 32'h0, 0, 0);
        issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h00000000, 0, 0);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0, TRAP ? 32'h123455EF : 32'hAAAA55EF, 0, 0);
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b1; a_size = 2'b10; a_addr = 32'h20; a_wdata = 32'h00000001;
        @(posedge clk); #1;
        a_req = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold[0] = 32'd0; hold[1] = 32'd0;
        @(negedge clk);
        check_idle_outputs("midreset");
        repeat (4) @(posedge clk);
        #1;
        issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h00000000, 0, 0);

        // Single-cycle latency instance.
        issue(1, 1, 2'b10, 0, 32'h08, 32'h11223344, 32'h0, 0, 0);
        issue(1, 0, 2'b00, 1, 32'h0B, 32'h0, 32'h00000011, 0, 0);
        issue(1, 0, 2'b01, 0, 32'h08, 32'h0, 32'h00003344, 0, 0);
        issue(1, 0, 2'b00, 0, 32'h09, 32'h0, 32'h00000033, 0, 0);
        issue(1, 0, 2'b01, 1, 32'h0A, 32'h0, 32'h00001122, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("qa_drained", qa.size(), 32'd0);
        check("qb_drained", qb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
